// File: rtl/hi_lo_unit.sv
// MIPS HI/LO multiply/divide unit: iterative shift-add multiply, restoring divide.
// Define HI_LO_FAST_MULT_EN for a single-cycle multiplier; divide stays iterative.
module hi_lo_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        op_valid,
  input  logic [5:0]  op_code,
  input  logic [31:0] operand_1,
  input  logic [31:0] operand_2,
  output logic        op_ready,
  output logic        busy,
  output logic [31:0] read_data,
  output logic        read_valid,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero
);

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX
  } state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [63:0] r_p;
  logic [31:0] r_b;
  logic [31:0] r_op1;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_is_div;
  logic        r_dz;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_rdata;
  logic        r_rvalid;
  logic        r_dbz;

  logic        w_acc;
  logic        w_mfhi;
  logic        w_mflo;
  logic        w_mthi;
  logic        w_mtlo;
  logic        w_mul;
  logic        w_div;
  logic        w_sgn;
  logic        w_mul_go;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [32:0] w_madd;
  logic [32:0] w_rsh;
  logic        w_ge;
  logic [31:0] w_dif;
  logic [63:0] w_pneg;
  logic [31:0] w_qneg;
  logic [31:0] w_rneg;

  assign w_acc  = op_valid && (r_state == S_IDLE);
  assign w_mfhi = w_acc && (op_code == F_MFHI);
  assign w_mflo = w_acc && (op_code == F_MFLO);
  assign w_mthi = w_acc && (op_code == F_MTHI);
  assign w_mtlo = w_acc && (op_code == F_MTLO);
  assign w_mul  = w_acc &&
                  ((op_code == F_MULT) || (op_code == F_MULTU));
  assign w_div  = w_acc &&
                  ((op_code == F_DIV) || (op_code == F_DIVU));
  assign w_sgn  = (op_code == F_MULT) || (op_code == F_DIV);

  assign w_a_neg = w_sgn && operand_1[31];
  assign w_b_neg = w_sgn && operand_2[31];
  assign w_a_mag = w_a_neg ? -operand_1 : operand_1;
  assign w_b_mag = w_b_neg ? -operand_2 : operand_2;

  // Multiply: multiplier in r_p[31:0], partial product in r_p[63:32]
  assign w_madd = {1'b0, r_p[63:32]} +
                  (r_p[0] ? {1'b0, r_b} : 33'd0);

  // Restoring divide: remainder in r_p[63:32], dividend/quotient below
  assign w_rsh = {r_p[63:32], r_p[31]};
  assign w_ge  = w_rsh[32] || (w_rsh[31:0] >= r_b);
  assign w_dif = w_rsh[31:0] - r_b;

  assign w_pneg = -r_p;
  assign w_qneg = -r_p[31:0];
  assign w_rneg = -r_p[63:32];

`ifdef HI_LO_FAST_MULT_EN
  logic [63:0] w_sprod;
  logic [63:0] w_uprod;
  logic [63:0] w_fprod;

  assign w_sprod  = $signed({{32{operand_1[31]}}, operand_1}) *
                    $signed({{32{operand_2[31]}}, operand_2});
  assign w_uprod  = {32'd0, operand_1} * {32'd0, operand_2};
  assign w_fprod  = (op_code == F_MULT) ? w_sprod : w_uprod;
  assign w_mul_go = 1'b0;
`else
  assign w_mul_go = w_mul;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= 5'd0;
      r_p      <= 64'd0;
      r_b      <= 32'd0;
      r_op1    <= 32'd0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_is_div <= 1'b0;
      r_dz     <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_rdata  <= 32'd0;
      r_rvalid <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_rvalid <= 1'b0;
      r_dbz    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_mthi) r_hi <= operand_1;
          if (w_mtlo) r_lo <= operand_1;
          if (w_mfhi) begin
            r_rdata  <= r_hi;
            r_rvalid <= 1'b1;
          end
          if (w_mflo) begin
            r_rdata  <= r_lo;
            r_rvalid <= 1'b1;
          end
`ifdef HI_LO_FAST_MULT_EN
          if (w_mul) {r_hi, r_lo} <= w_fprod;
`endif
          if (w_mul_go || w_div) begin
            r_p      <= {32'd0, w_a_mag};
            r_b      <= w_b_mag;
            r_op1    <= operand_1;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_is_div <= w_div;
            r_dz     <= (operand_2 == 32'd0);
            r_cnt    <= 5'd0;
            r_state  <= w_div ? S_DIV : S_MUL;
          end
        end
        S_MUL: begin
          r_p   <= {w_madd, r_p[31:1]};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_state <= S_FIX;
        end
        S_DIV: begin
          if (w_ge) r_p <= {w_dif, r_p[30:0], 1'b1};
          else      r_p <= {w_rsh[31:0], r_p[30:0], 1'b0};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_state <= S_FIX;
        end
        S_FIX: begin
          r_state <= S_IDLE;
          if (!r_is_div) begin
            {r_hi, r_lo} <= r_neg_q ? w_pneg : r_p;
          end else if (r_dz) begin
            r_hi  <= r_op1;
            r_lo  <= 32'hFFFF_FFFF;
            r_dbz <= 1'b1;
          end else begin
            r_lo <= r_neg_q ? w_qneg : r_p[31:0];
            r_hi <= r_neg_r ? w_rneg : r_p[63:32];
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign op_ready    = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign read_data   = r_rdata;
  assign read_valid  = r_rvalid;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_hi_lo_unit.sv
// Directed and randomized bench for hi_lo_unit against an arithmetic model.
// Honors HI_LO_FAST_MULT_EN when the same macro is defined for the bench.
module tb_hi_lo_unit;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

`ifdef HI_LO_FAST_MULT_EN
  localparam int MUL_CYC = 0;
`else
  localparam int MUL_CYC = 33;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        op_valid;
  logic [5:0]  op_code;
  logic [31:0] operand_1;
  logic [31:0] operand_2;
  logic        op_ready;
  logic        busy;
  logic [31:0] read_data;
  logic        read_valid;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  always #5 clk = ~clk;

  hi_lo_unit dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .op_valid    (op_valid),
    .op_code     (op_code),
    .operand_1   (operand_1),
    .operand_2   (operand_2),
    .op_ready    (op_ready),
    .busy        (busy),
    .read_data   (read_data),
    .read_valid  (read_valid),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural result of one op, from plain 64-bit arithmetic
  function automatic void model(input logic [5:0] c,
                                input logic [31:0] a, b,
                                inout logic [31:0] h, l,
                                output logic dz, output int cyc);
    longint sa, sb, q, r;
    logic [63:0] pu;
    dz  = 1'b0;
    cyc = 0;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    case (c)
      F_MTHI: h = a;
      F_MTLO: l = a;
      F_MULT: begin
        q = sa * sb;
        {h, l} = q;
        cyc = MUL_CYC;
      end
      F_MULTU: begin
        pu = {32'd0, a} * {32'd0, b};
        {h, l} = pu;
        cyc = MUL_CYC;
      end
      F_DIV, F_DIVU: begin
        cyc = 33;
        if (b == 32'd0) begin
          h  = a;
          l  = 32'hFFFF_FFFF;
          dz = 1'b1;
        end else if (c == F_DIV) begin
          q = sa / sb;
          r = sa % sb;
          l = q[31:0];
          h = r[31:0];
        end else begin
          l = a / b;
          h = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [5:0] c,
                        input logic [31:0] a, b);
    logic dz;
    int cyc;
    int n;
    model(c, a, b, m_hi, m_lo, dz, cyc);
    @(negedge clk);
    op_valid = 1'b1; op_code = c; operand_1 = a; operand_2 = b;
    @(posedge clk);
    #1 op_valid = 1'b0;
    operand_1 = $urandom; operand_2 = $urandom;
    @(negedge clk);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk({tag, " busy_cycles"}, n, cyc);
    chk({tag, " hi"}, hi, m_hi);
    chk({tag, " lo"}, lo, m_lo);
    chk({tag, " dbz"}, {31'd0, div_by_zero}, {31'd0, dz});
    @(negedge clk);
    chk({tag, " dbz_off"}, {31'd0, div_by_zero}, 32'd0);
  endtask

  task automatic do_read(input string tag, input logic [5:0] c,
                         input logic [31:0] exp);
    @(negedge clk);
    op_valid = 1'b1; op_code = c;
    @(posedge clk);
    #1 op_valid = 1'b0;
    @(negedge clk);
    chk({tag, " rvalid"}, {31'd0, read_valid}, 32'd1);
    chk({tag, " rdata"}, read_data, exp);
    @(negedge clk);
    chk({tag, " rvalid_off"}, {31'd0, read_valid}, 32'd0);
    chk({tag, " rdata_hold"}, read_data, exp);
  endtask

  initial begin
    logic [5:0] codes [6];
    logic [31:0] a, b;
    logic dz;
    int cyc, n;
    codes[0] = F_MULT; codes[1] = F_MULTU; codes[2] = F_DIV;
    codes[3] = F_DIVU; codes[4] = F_MTHI;  codes[5] = F_MTLO;
    reset_n = 1'b0; op_valid = 1'b0; op_code = 6'd0;
    operand_1 = 32'd0; operand_2 = 32'd0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst hi", hi, 32'd0);
    chk("rst lo", lo, 32'd0);
    chk("rst rdata", read_data, 32'd0);
    chk("rst rvalid", {31'd0, read_valid}, 32'd0);
    chk("rst dbz", {31'd0, div_by_zero}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst ready", {31'd0, op_ready}, 32'd1);

    // Directed vectors
    run_op("mult_neg", F_MULT, 32'hFFFF_FFFE, 32'h0000_0003);
    chk("mult_neg hi_k", hi, 32'hFFFF_FFFF);
    chk("mult_neg lo_k", lo, 32'hFFFF_FFFA);
    run_op("div_neg7", F_DIV, 32'hFFFF_FFF9, 32'd2);
    chk("div_neg7 lo_k", lo, 32'hFFFF_FFFD);
    chk("div_neg7 hi_k", hi, 32'hFFFF_FFFF);
    run_op("divu_7", F_DIVU, 32'd7, 32'd2);
    chk("divu_7 lo_k", lo, 32'd3);
    chk("divu_7 hi_k", hi, 32'd1);
    run_op("divu_z", F_DIVU, 32'h1234_5678, 32'd0);
    chk("divu_z hi_k", hi, 32'h1234_5678);
    chk("divu_z lo_k", lo, 32'hFFFF_FFFF);
    run_op("div_z", F_DIV, 32'h8765_4321, 32'd0);
    run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf lo_k", lo, 32'h8000_0000);
    chk("div_ovf hi_k", hi, 32'd0);
    run_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mult_min", F_MULT, 32'h8000_0000, 32'h8000_0000);

    // MTHI then MFHI back-to-back
    @(negedge clk);
    op_valid = 1'b1; op_code = F_MTHI; operand_1 = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 op_code = F_MFHI; operand_1 = $urandom;
    @(negedge clk);
    chk("mthi hi", hi, 32'hDEAD_BEEF);
    @(posedge clk);
    #1 op_valid = 1'b0;
    @(negedge clk);
    chk("mfhi rvalid", {31'd0, read_valid}, 32'd1);
    chk("mfhi rdata", read_data, 32'hDEAD_BEEF);
    m_hi = 32'hDEAD_BEEF;

    // MFLO stalled behind a divide
    a = 32'd1000; b = 32'hFFFF_FFF9;
    model(F_DIV, a, b, m_hi, m_lo, dz, cyc);
    @(negedge clk);
    op_valid = 1'b1; op_code = F_DIV; operand_1 = a; operand_2 = b;
    @(posedge clk);
    #1 op_code = F_MFLO; operand_1 = $urandom; operand_2 = $urandom;
    @(negedge clk);
    n = 0;
    while (op_ready !== 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("stall cycles", n, 32'd33);
    @(posedge clk);
    #1 op_valid = 1'b0;
    @(negedge clk);
    chk("stall rvalid", {31'd0, read_valid}, 32'd1);
    chk("stall rdata", read_data, m_lo);
    chk("stall hi", hi, m_hi);

    // Unlisted funct codes are ignored
    @(negedge clk);
    op_valid = 1'b1; op_code = 6'b011100;
    operand_1 = $urandom; operand_2 = $urandom;
    @(posedge clk);
    #1 op_code = 6'b000000;
    @(posedge clk);
    #1 op_valid = 1'b0;
    @(negedge clk);
    chk("ign busy", {31'd0, busy}, 32'd0);
    chk("ign rvalid", {31'd0, read_valid}, 32'd0);
    chk("ign hi", hi, m_hi);
    chk("ign lo", lo, m_lo);

    // Randomized ops with readback
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
      run_op($sformatf("rnd%0d", i), codes[$urandom_range(0, 5)], a, b);
      do_read($sformatf("rnd%0d mfhi", i), F_MFHI, m_hi);
      do_read($sformatf("rnd%0d mflo", i), F_MFLO, m_lo);
    end

    // Reset in the middle of MULTU
    @(negedge clk);
    op_valid = 1'b1; op_code = F_MULTU;
    operand_1 = 32'h0001_2345; operand_2 = 32'h0006_789A;
    @(posedge clk);
    #1 op_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("abort hi", hi, 32'd0);
    chk("abort lo", lo, 32'd0);
    chk("abort ready", {31'd0, op_ready}, 32'd1);
    chk("abort busy", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    chk("abort late hi", hi, 32'd0);
    chk("abort late lo", lo, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
